// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 pixel stream front end:
// FSM state encoding, default frame geometry and error-bit positions.
package ov7670_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam int ERR_SHORT_LINE  = 0;
  localparam int ERR_LONG_LINE   = 1;
  localparam int ERR_SHORT_FRAME = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SYNC_HI = 2'd1;
  localparam logic [1:0] ST_SYNC_LO = 2'd2;
  localparam logic [1:0] ST_ACTIVE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SYNC_HI = ST_SYNC_HI,
    SYNC_LO = ST_SYNC_LO,
    ACTIVE  = ST_ACTIVE
  } state_t;

endpackage

// File: rtl/ov7670_sync_edge.sv
// Input register stage for the camera bus: registers vsync/href/d on every
// pclk edge and derives single-cycle rise/fall pulses from the q/qq pair.
module ov7670_sync_edge (
  input  logic       pclk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] d,
  output logic       href_q,
  output logic [7:0] d_q,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_rise,
  output logic       href_fall
);

  logic vsync_q;
  logic vsync_qq;
  logic href_qq;

  // two-deep history of the sync pins, one register for the data byte
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      d_q      <= 8'd0;
    end else begin
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
      href_q   <= href;
      href_qq  <= href_q;
      d_q      <= d;
    end
  end

  assign vsync_rise = vsync_q & ~vsync_qq;
  assign vsync_fall = ~vsync_q & vsync_qq;
  assign href_rise  = href_q & ~href_qq;
  assign href_fall  = ~href_q & href_qq;

endmodule

// File: rtl/ov7670_pixel_stream.sv
// OV7670 parallel bus to per-pixel luma stream.
//
// state   | meaning
// IDLE    | waiting for arm
// SYNC_HI | armed, waiting for vsync rise (start of vertical blank)
// SYNC_LO | in vertical blank, waiting for vsync fall
// ACTIVE  | capturing lines until last row completes or vsync rises
//
// Optional build macro LINE_CHECK_EN adds the sticky line/frame checker on err;
// without it err is tied to zero.
module ov7670_pixel_stream
  import ov7670_pkg::*;
#(
  parameter  int H_ACTIVE   = DEF_H_ACTIVE,
  parameter  int V_ACTIVE   = DEF_V_ACTIVE,
  parameter  int Y_PHASE    = 0,
  parameter  int CONTINUOUS = 0,
  localparam int COL_W      = $clog2(H_ACTIVE),
  localparam int ROW_W      = $clog2(V_ACTIVE)
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic             vsync,
  input  logic             href,
  input  logic [7:0]       d,
  input  logic             arm,
  output logic             busy,
  output logic             pix_valid,
  output logic [7:0]       pix_y,
  output logic [COL_W-1:0] pix_col,
  output logic [ROW_W-1:0] pix_row,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic             frame_done,
  output logic [2:0]       err
);

  localparam logic [COL_W:0]   H_FULL = (COL_W+1)'(H_ACTIVE);
  localparam logic [COL_W:0]   H_LAST = (COL_W+1)'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] V_LAST = ROW_W'(V_ACTIVE - 1);
  localparam logic             Y_SEL  = Y_PHASE[0];

  logic       href_q, vsync_rise, vsync_fall, href_rise, href_fall;
  logic [7:0] d_q;

  ov7670_sync_edge u_sync (
    .pclk       (pclk),
    .reset      (reset),
    .vsync      (vsync),
    .href       (href),
    .d          (d),
    .href_q     (href_q),
    .d_q        (d_q),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_rise  (href_rise),
    .href_fall  (href_fall)
  );

  state_t           state;
  logic             phase;
  // col saturates at H_ACTIVE so overlong lines stop advancing it
  logic [COL_W:0]   col;
  logic [ROW_W-1:0] row;

  logic           in_active, is_luma, keep;
  logic           line_end, full_end, trunc_end, frame_end;
  logic [COL_W:0] col_eff;

  assign in_active = (state == ACTIVE);
  assign is_luma   = href_q & (phase == Y_SEL);
  // first byte of a line arrives on the same cycle as href_rise
  assign col_eff   = href_rise ? '0 : col;
  assign keep      = in_active & is_luma & (col_eff < H_FULL);
  assign line_end  = in_active & href_fall & (col != '0);
  assign full_end  = line_end & (row == V_LAST);
  assign trunc_end = in_active & vsync_rise & ~full_end;
  assign frame_end = full_end | trunc_end;
  assign busy      = (state != IDLE);

  // byte phase within href: 0 on the first byte, toggling each byte
  always_ff @(posedge pclk or posedge reset) begin
    if (reset)        phase <= 1'b0;
    else if (!href_q) phase <= 1'b0;
    else              phase <= ~phase;
  end

  // frame sequencing
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (arm)        state <= SYNC_HI;
        SYNC_HI: if (vsync_rise) state <= SYNC_LO;
        SYNC_LO: if (vsync_fall) state <= ACTIVE;
        ACTIVE:  if (frame_end)  state <= (CONTINUOUS != 0) ? SYNC_HI : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // column and row position within the captured frame
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (state == SYNC_LO) begin
      col <= '0;
      row <= '0;
    end else if (in_active) begin
      if (keep)           col <= col_eff + 1'b1;
      else if (href_rise) col <= '0;
      if (line_end && !full_end) row <= row + 1'b1;
    end
  end

  logic             stg_valid, stg_sof, stg_eol, stg_eof, stg_done;
  logic [7:0]       stg_y;
  logic [COL_W-1:0] stg_col;
  logic [ROW_W-1:0] stg_row;

  // first pipeline stage: decide and tag the pixel
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      stg_valid <= 1'b0;
      stg_y     <= 8'd0;
      stg_col   <= '0;
      stg_row   <= '0;
      stg_sof   <= 1'b0;
      stg_eol   <= 1'b0;
      stg_eof   <= 1'b0;
      stg_done  <= 1'b0;
    end else begin
      stg_valid <= keep;
      stg_y     <= d_q;
      stg_col   <= col_eff[COL_W-1:0];
      stg_row   <= row;
      stg_sof   <= keep & (row == '0) & (col_eff == '0);
      stg_eol   <= keep & (col_eff == H_LAST);
      stg_eof   <= keep & (col_eff == H_LAST) & (row == V_LAST);
      stg_done  <= frame_end;
    end
  end

  // output stage: registered stream outputs
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      pix_valid  <= 1'b0;
      pix_y      <= 8'd0;
      pix_col    <= '0;
      pix_row    <= '0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= stg_valid;
      pix_y      <= stg_y;
      pix_col    <= stg_col;
      pix_row    <= stg_row;
      sof        <= stg_sof;
      eol        <= stg_eol;
      eof        <= stg_eof;
      frame_done <= stg_done;
    end
  end

`ifdef LINE_CHECK_EN
  logic [2:0] err_r;

  // sticky line/frame length errors, cleared by an accepted arm
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      err_r <= 3'b000;
    end else if (state == IDLE && arm) begin
      err_r <= 3'b000;
    end else begin
      if (in_active && href_fall && (col < H_FULL))   err_r[ERR_SHORT_LINE]  <= 1'b1;
      if (in_active && is_luma && (col_eff == H_FULL)) err_r[ERR_LONG_LINE]   <= 1'b1;
      if (trunc_end)                                  err_r[ERR_SHORT_FRAME] <= 1'b1;
    end
  end

  assign err = err_r;
`else
  assign err = 3'b000;
`endif

endmodule

// File: tb/tb_ov7670_pixel_stream.sv
// Scoreboard bench: two instances (H=4, V=2) share the camera bus.
// u0: Y_PHASE=0 single-shot, u1: Y_PHASE=1 continuous.
module tb_ov7670_pixel_stream;

  localparam int H = 4;
  localparam int V = 2;
`ifdef LINE_CHECK_EN
  localparam bit LCE = 1'b1;
`else
  localparam bit LCE = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] y;
    logic [1:0] col;
    logic       row;
    logic       sof;
    logic       eol;
    logic       eof;
  } pix_t;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       href = 1'b0;
  logic [7:0] d = 8'd0;
  logic       arm0 = 1'b0;
  logic       arm1 = 1'b0;

  logic       b0, v0, s0, e0, f0, dn0;
  logic [7:0] y0;
  logic [1:0] c0;
  logic       r0;
  logic [2:0] er0;
  logic       b1, v1, s1, e1, f1, dn1;
  logic [7:0] y1;
  logic [1:0] c1;
  logic       r1;
  logic [2:0] er1;

  always #5 pclk = ~pclk;

  ov7670_pixel_stream #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_PHASE(0), .CONTINUOUS(0)) u0 (
    .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .d(d), .arm(arm0),
    .busy(b0), .pix_valid(v0), .pix_y(y0), .pix_col(c0), .pix_row(r0),
    .sof(s0), .eol(e0), .eof(f0), .frame_done(dn0), .err(er0));

  ov7670_pixel_stream #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_PHASE(1), .CONTINUOUS(1)) u1 (
    .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .d(d), .arm(arm1),
    .busy(b1), .pix_valid(v1), .pix_y(y1), .pix_col(c1), .pix_row(r1),
    .sof(s1), .eol(e1), .eof(f1), .frame_done(dn1), .err(er1));

  int   n_cmp = 0;
  int   n_bad = 0;
  pix_t q0[$];
  pix_t q1[$];
  bit   ignore = 1'b0;

  // reference model, frame level: 0 idle, 1 waiting for vsync, 2 capturing
  int         mstat[2];
  int         mrow[2];
  int         mdone[2];
  int         done_seen[2];
  logic [2:0] merr[2];
  logic [7:0] lb[16];
  int         lens[7] = '{4, 6, 8, 8, 8, 10, 12};

  task automatic model_arm(input int k);
    if (mstat[k] == 0) begin
      mstat[k] = 1;
      merr[k]  = 3'b000;
    end
  endtask

  task automatic model_vsync(input int k);
    if (mstat[k] == 2) begin
      mdone[k]++;
      merr[k][2] = 1'b1;
      mstat[k] = (k == 1) ? 1 : 0;
    end else if (mstat[k] == 1) begin
      mstat[k] = 2;
      mrow[k]  = 0;
    end
  endtask

  task automatic model_line(input int k, input int n);
    int   nl;
    pix_t p;
    if (mstat[k] != 2) return;
    nl = 0;
    for (int i = 0; i < n; i++) begin
      if ((i % 2) == k) begin
        if (nl < H) begin
          p.y   = lb[i];
          p.col = 2'(nl);
          p.row = 1'(mrow[k]);
          p.sof = (mrow[k] == 0) && (nl == 0);
          p.eol = (nl == H - 1);
          p.eof = (nl == H - 1) && (mrow[k] == V - 1);
          if (k == 0) q0.push_back(p);
          else        q1.push_back(p);
        end
        nl++;
      end
    end
    if (nl > H) merr[k][1] = 1'b1;
    if (nl < H) merr[k][0] = 1'b1;
    if (nl > 0) begin
      if (mrow[k] == V - 1) begin
        mdone[k]++;
        mstat[k] = (k == 1) ? 1 : 0;
      end else begin
        mrow[k]++;
      end
    end
  endtask

  task automatic check_pix(input int k, input pix_t act);
    pix_t exp;
    n_cmp++;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      n_bad++;
      $display("FAIL pix%0d unexpected: got y=%0d col=%0d row=%0d sof/eol/eof=%b%b%b, none expected",
               k, act.y, act.col, act.row, act.sof, act.eol, act.eof);
    end else begin
      exp = (k == 0) ? q0.pop_front() : q1.pop_front();
      if (act !== exp) begin
        n_bad++;
        $display("FAIL pix%0d got y=%0d col=%0d row=%0d sof/eol/eof=%b%b%b want y=%0d col=%0d row=%0d sof/eol/eof=%b%b%b",
                 k, act.y, act.col, act.row, act.sof, act.eol, act.eof,
                 exp.y, exp.col, exp.row, exp.sof, exp.eol, exp.eof);
      end
    end
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_state();
    cmp("busy0", int'(b0), int'(mstat[0] != 0));
    cmp("busy1", int'(b1), int'(mstat[1] != 0));
    cmp("err0", int'(er0), LCE ? int'(merr[0]) : 0);
    cmp("err1", int'(er1), LCE ? int'(merr[1]) : 0);
    cmp("frame_done0", done_seen[0], mdone[0]);
    cmp("frame_done1", done_seen[1], mdone[1]);
  endtask

  // monitor: pop and compare whenever a DUT presents a pixel
  initial begin
    forever begin
      @(negedge pclk);
      if (dn0) done_seen[0]++;
      if (dn1) done_seen[1]++;
      if (v0 && !ignore) check_pix(0, {y0, c0, r0, s0, e0, f0});
      if (v1 && !ignore) check_pix(1, {y1, c1, r1, s1, e1, f1});
    end
  end

  task automatic gap(input bit a0, input bit a1);
    repeat (2) @(negedge pclk);
    @(negedge pclk);
    if (a0) begin arm0 = 1'b1; model_arm(0); end
    if (a1) begin arm1 = 1'b1; model_arm(1); end
    @(negedge pclk);
    arm0 = 1'b0;
    arm1 = 1'b0;
    repeat (3) @(negedge pclk);
    check_state();
  endtask

  task automatic vsync_pulse();
    model_vsync(0);
    model_vsync(1);
    repeat (3) begin
      @(negedge pclk);
      vsync = 1'b1;
    end
    @(negedge pclk);
    vsync = 1'b0;
    gap(1'b0, 1'b0);
  endtask

  task automatic send_line(input int n, input bit rnd, input int base);
    for (int i = 0; i < n; i++) lb[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
    model_line(0, n);
    model_line(1, n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      href = 1'b1;
      d    = lb[i];
    end
    @(negedge pclk);
    href = 1'b0;
    d    = 8'd0;
  endtask

  task automatic check_zero(input int k, input logic [20:0] act);
    cmp($sformatf("reset_outputs%0d", k), int'(act), 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mstat[k] = 0; mrow[k] = 0; mdone[k] = 0; done_seen[k] = 0; merr[k] = 3'b000;
    end
    repeat (3) @(negedge pclk);
    check_zero(0, {v0, y0, c0, r0, s0, e0, f0, dn0, b0, er0});
    check_zero(1, {v1, y1, c1, r1, s1, e1, f1, dn1, b1, er1});
    reset = 1'b0;

    // full frame, two exact lines of 10..17
    gap(1'b1, 1'b1);
    vsync_pulse();
    send_line(8, 1'b0, 10);
    gap(1'b0, 1'b0);
    send_line(8, 1'b0, 10);
    gap(1'b0, 1'b0);

    // long line then truncation by the next vsync; arm mid-frame ignored
    gap(1'b1, 1'b0);
    vsync_pulse();
    send_line(12, 1'b0, 20);
    gap(1'b1, 1'b1);
    vsync_pulse();
    send_line(8, 1'b0, 40);
    gap(1'b0, 1'b0);
    send_line(8, 1'b0, 50);
    gap(1'b0, 1'b0);

    // reset in the middle of row 1
    gap(1'b1, 1'b1);
    vsync_pulse();
    send_line(8, 1'b0, 60);
    gap(1'b0, 1'b0);
    ignore = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      href = 1'b1;
      d    = 8'(70 + i);
    end
    @(negedge pclk);
    reset = 1'b1;
    #1;
    check_zero(0, {v0, y0, c0, r0, s0, e0, f0, dn0, b0, er0});
    check_zero(1, {v1, y1, c1, r1, s1, e1, f1, dn1, b1, er1});
    @(negedge pclk);
    href = 1'b0;
    d    = 8'd0;
    repeat (2) @(negedge pclk);
    reset = 1'b0;
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      mstat[k] = 0; merr[k] = 3'b000;
    end
    @(negedge pclk);
    ignore = 1'b0;
    gap(1'b1, 1'b0);
    vsync_pulse();
    send_line(8, 1'b0, 80);
    gap(1'b0, 1'b0);
    send_line(8, 1'b0, 90);
    gap(1'b0, 1'b0);

    // randomized frames: 1..3 lines of assorted lengths, random arms
    for (int f = 0; f < 25; f++) begin
      gap($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      vsync_pulse();
      for (int l = 0, nl = $urandom_range(1, 3); l < nl; l++) begin
        send_line(lens[$urandom_range(0, 6)], 1'b1, 0);
        gap($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      end
    end

    vsync_pulse();
    repeat (10) @(negedge pclk);
    check_state();
    cmp("queue0_empty", q0.size(), 0);
    cmp("queue1_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
